irq_priority_dispatch: RTL and testbench
========================================

# irq_priority_dispatch

Pending-interrupt collector and dispatcher. It edge-detects N request lines and latches them into a pending register. It presents the lowest-numbered pending request as an index on a valid/ready interface, and clears that pending bit when the downstream consumer accepts it. It sits directly upstream of the consumer of `pos` and contains the lowest-index-wins priority encoding internally, registered and handshaken.

## Interface
- `N`, default 8: number of request lines; legal 2..256.
- `PW`, default `$clog2(N)` (3): index width; derived, not overridden.
- `clk` input 1: sole clock, rising edge.
- `areset_n` input 1: asynchronous, active-low reset. Asserts immediately; deasserts synchronously to `clk` (external synchronizer).
- `irq` input N: request levels, synchronous to `clk`. A 0→1 transition raises a request.
- `irq_mask` input N: 1 = line eligible for dispatch. Present only with `IRQ_MASK_EN`.
- `out_valid` output 1: an index is being presented.
- `out_pos` output PW: index of the presented request.
- `out_ready` input 1: consumer accepts `out_pos` this cycle.
- `pending` output N: current pending register.
- `overrun` output 1: sticky; a rise arrived on a line already pending.
- `overrun_clr` input 1: synchronous clear of `overrun`.

## Operation
- `irq_d` holds `irq` delayed by one clock. `rise = irq & ~irq_d`.
- `acc = out_valid & out_ready` (handshake).
- `clr` = one-hot(`out_pos`) when `acc`, else 0.
- `pending_next = (pending & ~clr) | rise`. Set wins over clear on the same bit.
- `cand = (pending & ~clr) | rise`, ANDed with `irq_mask` when `IRQ_MASK_EN` is defined.
- Output stage loads only when `!out_valid || acc`:
  - `out_valid <= |cand`
  - `out_pos <=` lowest set index of `cand`, or 0 if `cand` is empty.
- Otherwise `out_valid` and `out_pos` hold. A presented index is never withdrawn or changed before acceptance, even if a lower-index request arrives.
- A presented bit stays set in `pending` until its handshake.
- `overrun` sets when, for some line i, `rise[i] & pending[i] & ~clr[i]`. `overrun_clr` clears it. Set wins if both occur in the same cycle.
- A rise on the bit being accepted in the same cycle is legal: the bit stays pending, is eligible again immediately, and does not set `overrun`.
- Levels held high produce exactly one request. The line must fall and rise again to request again.

## Timing
- Reset values: `irq_d` = 0, `pending` = 0, `out_valid` = 0, `out_pos` = 0, `overrun` = 0.
- Because `irq_d` resets to 0, a line already high when reset deasserts counts as a rise on the first edge.
- Latency: `irq` first sampled high at edge k → `pending[i]` = 1 and (if idle) `out_valid` = 1 with `out_pos` = i after edge k.
- Back-to-back: accepting at edge k loads the next-lowest pending index at that same edge, giving one dispatch per cycle with no bubbles.
- Accepted bit clears in `pending` after the accepting edge.
- `out_ready` may be asserted with `out_valid` low; this has no effect.
- Reset asserted mid-operation: all state clears asynchronously, and in-flight pending requests are lost by design.

## Configuration
- `IRQ_MASK_EN` defined: `irq_mask` port exists. Masked lines still latch into `pending` and can still raise `overrun`, but are never selected. Unmasking an already-pending line makes it eligible on the next load.
- `IRQ_MASK_EN` undefined: no `irq_mask` port; all lines are eligible.

## Test plan
- **Single request.** N=8, `out_ready` = 0, `irq[5]` 0→1 at edge k → after edge k: `out_valid` = 1, `out_pos` = 5, `pending` = 8'h20. Raise `out_ready` for one cycle → `pending` = 0, `out_valid` = 0.
- **Priority and hold.** `irq[6]` rises, then 2 cycles later `irq[1]` rises, with `out_ready` = 0 → `out_pos` stays 6 and `pending` = 8'h42. Accept → `out_pos` = 1 on the next cycle. Accept → `out_valid` = 0.
- **Burst, back-to-back.** `irq` 8'h00→8'hA5 in one cycle, `out_ready` held 1 → `out_pos` sequence 0, 2, 5, 7 on consecutive cycles, then `out_valid` = 0, `pending` = 0.
- **Overrun and simultaneous rise/accept.**
  - `irq[3]` pulses twice while unaccepted → `overrun` = 1. `overrun_clr` → 0.
  - Re-rise `irq[3]` on its accept cycle → `pending[3]` stays 1, `overrun` stays 0, `out_pos` = 3 again.
- **Reset mid-operation.** `pending` = 8'h18 with `out_valid` = 1; pulse `areset_n` low between edges → all outputs 0 immediately. `irq` held at 8'h18 → `pending` = 8'h18 on the first edge after release.
- **Masking (`IRQ_MASK_EN`).** `irq_mask` = 8'hFE, `irq[0]` and `irq[4]` rise → `out_pos` = 4 and `pending` = 8'h11. Accept, then set `irq_mask` = 8'hFF → `out_pos` = 0 on the next cycle.

Source files
------------

// File: rtl/irq_priority_dispatch.sv
// rtl/irq_priority_dispatch.sv - edge-detected pending interrupt collector with lowest-index valid/ready dispatch
// Optional IRQ_MASK_EN adds the irq_mask eligibility input.
module irq_priority_dispatch #(
   parameter int N = 8,
   localparam int PW = $clog2(N)
) (
   input  logic          clk,
   input  logic          areset_n,
   input  logic [N-1:0]  irq,
`ifdef IRQ_MASK_EN
   input  logic [N-1:0]  irq_mask,
`endif
   output logic          out_valid,
   output logic [PW-1:0] out_pos,
   input  logic          out_ready,
   output logic [N-1:0]  pending,
   output logic          overrun,
   input  logic          overrun_clr
);

   logic [N-1:0]  irq_d;
   logic [N-1:0]  rise;
   logic [N-1:0]  clr;
   logic [N-1:0]  kept;
   logic [N-1:0]  pending_next;
   logic [N-1:0]  cand;
   logic [PW-1:0] sel;
   logic          acc;
   logic          load;
   logic          overrun_set;

   assign rise         = irq & ~irq_d;
   assign acc          = out_valid & out_ready;
   assign clr          = acc ? (N'(1) << out_pos) : '0;
   assign kept         = pending & ~clr;
   assign pending_next = kept | rise;
   assign overrun_set  = |(rise & kept);
   assign load         = !out_valid || acc;

`ifdef IRQ_MASK_EN
   assign cand = pending_next & irq_mask;
`else
   assign cand = pending_next;
`endif

   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      sel = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (cand[i]) begin
            sel = PW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         irq_d     <= '0;
         pending   <= '0;
         out_valid <= 1'b0;
         out_pos   <= '0;
         overrun   <= 1'b0;
      end else begin
         irq_d   <= irq;
         pending <= pending_next;
         if (load) begin
            out_valid <= |cand;
            out_pos   <= sel;
         end
         if (overrun_set) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_irq_priority_dispatch.sv
// tb/tb_irq_priority_dispatch.sv - scoreboard bench for irq_priority_dispatch
module tb_irq_priority_dispatch;

   localparam int N  = 8;
   localparam int PW = $clog2(N);

   logic          clk = 1'b0;
   logic          areset_n;
   logic [N-1:0]  irq;
   logic [N-1:0]  irq_mask;
   logic          out_valid;
   logic [PW-1:0] out_pos;
   logic          out_ready;
   logic [N-1:0]  pending;
   logic          overrun;
   logic          overrun_clr;

   int n_checks = 0;
   int n_fail   = 0;
   logic [PW-1:0] exp_q[$];

   always #5 clk = ~clk;

   irq_priority_dispatch #(.N(N)) dut (
      .clk         (clk),
      .areset_n    (areset_n),
      .irq         (irq),
`ifdef IRQ_MASK_EN
      .irq_mask    (irq_mask),
`endif
      .out_valid   (out_valid),
      .out_pos     (out_pos),
      .out_ready   (out_ready),
      .pending     (pending),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every accepted index must match the next expected dispatch.
   always @(negedge clk) begin
      if (areset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_dispatch", {24'h0, 5'h0, out_pos}, 32'hFFFF_FFFF);
         end else begin
            check("dispatch_pos", {29'h0, out_pos}, {29'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      areset_n    = 1'b0;
      irq         = '0;
      irq_mask    = '1;
      out_ready   = 1'b0;
      overrun_clr = 1'b0;
      tick();
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_pos", out_pos, 0);
      check("rst_pending", pending, 0);
      check("rst_overrun", overrun, 0);
      areset_n = 1'b1;
      tick();

      // single request
      irq = 8'h20;
      exp_q.push_back(3'd5);
      tick();
      check("single_valid", out_valid, 1);
      check("single_pos", out_pos, 5);
      check("single_pending", pending, 8'h20);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("single_pend_clr", pending, 0);
      check("single_valid_clr", out_valid, 0);
      irq = '0;
      tick();

      // priority and hold
      irq = 8'h40;
      exp_q.push_back(3'd6);
      exp_q.push_back(3'd1);
      tick();
      tick();
      tick();
      irq = 8'h42;
      tick();
      check("hold_pos", out_pos, 6);
      check("hold_pending", pending, 8'h42);
      out_ready = 1'b1;
      tick();
      check("prio_pos", out_pos, 1);
      check("prio_valid", out_valid, 1);
      tick();
      out_ready = 1'b0;
      check("prio_idle", out_valid, 0);
      check("prio_pend", pending, 0);
      irq = '0;
      tick();

      // burst back-to-back
      irq = 8'hA5;
      out_ready = 1'b1;
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd5);
      exp_q.push_back(3'd7);
      tick();
      check("burst0", out_pos, 0);
      tick();
      check("burst2", out_pos, 2);
      tick();
      check("burst5", out_pos, 5);
      tick();
      check("burst7", out_pos, 7);
      check("burst7_valid", out_valid, 1);
      tick();
      check("burst_idle", out_valid, 0);
      check("burst_pend", pending, 0);
      out_ready = 1'b0;
      irq = '0;
      tick();

      // overrun
      irq = 8'h08;
      exp_q.push_back(3'd3);
      tick();
      check("ovr_none", overrun, 0);
      irq = '0;
      tick();
      irq = 8'h08;
      tick();
      check("ovr_set", overrun, 1);
      check("ovr_pending", pending, 8'h08);
      irq = '0;
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check("ovr_clr", overrun, 0);

      // re-rise on the accept cycle
      irq = 8'h08;
      out_ready = 1'b1;
      exp_q.push_back(3'd3);
      tick();
      out_ready = 1'b0;
      check("rerise_pending", pending, 8'h08);
      check("rerise_overrun", overrun, 0);
      check("rerise_pos", out_pos, 3);
      check("rerise_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("rerise_done", pending, 0);
      irq = '0;
      tick();

      // reset mid-operation
      irq = 8'h18;
      tick();
      check("mid_pending", pending, 8'h18);
      check("mid_valid", out_valid, 1);
      #2;
      areset_n = 1'b0;
      #1;
      check("async_valid", out_valid, 0);
      check("async_pos", out_pos, 0);
      check("async_pending", pending, 0);
      check("async_overrun", overrun, 0);
      #1;
      areset_n = 1'b1;
      exp_q.push_back(3'd3);
      exp_q.push_back(3'd4);
      tick();
      check("post_rst_pending", pending, 8'h18);
      check("post_rst_pos", out_pos, 3);
      out_ready = 1'b1;
      tick();
      check("post_rst_pos4", out_pos, 4);
      tick();
      out_ready = 1'b0;
      check("post_rst_idle", out_valid, 0);
      irq = '0;
      tick();

`ifdef IRQ_MASK_EN
      irq_mask = 8'hFE;
      irq = 8'h11;
      exp_q.push_back(3'd4);
      exp_q.push_back(3'd0);
      tick();
      check("mask_pos", out_pos, 4);
      check("mask_pending", pending, 8'h11);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("mask_blocked", out_valid, 0);
      check("mask_kept", pending, 8'h01);
      irq_mask = 8'hFF;
      tick();
      check("unmask_pos", out_pos, 0);
      check("unmask_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("unmask_idle", out_valid, 0);
      irq = '0;
      tick();
`endif

      // ready with nothing valid has no effect
      out_ready = 1'b1;
      tick();
      check("ready_idle", out_valid, 0);
      out_ready = 1'b0;

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         tick();
      end
      check("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
